// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a one-cycle byte strobe through a small FIFO.
// Stores never stall: bytes queue up and drain at the baud rate.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_full,
  output logic       tx_idle,
  output logic       tx_overflow,
  output logic       uart_tx_line
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  state_t           r_state;
  state_t           w_stateNext;
  logic [CNT_W-1:0] r_baud;
  logic [CNT_W-1:0] w_baudNext;
  logic [2:0]       r_bitIdx;
  logic [2:0]       w_bitIdxNext;
  logic [2:0]       w_bitIdxInc;
  logic [7:0]       r_shift;
  logic             r_line;
  logic             w_lineNext;

  logic             w_baudDone;
  logic             w_notEmpty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_baudDone  = (r_baud == BAUD_LAST);
  assign w_notEmpty  = (r_count != '0);
  assign w_bitIdxInc = r_bitIdx + 3'd1;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push      = tx_data_valid && ((r_count != DEPTH_CNT) || w_pop);
  assign w_drop      = tx_data_valid && !w_push;

  always_comb begin
    w_stateNext  = r_state;
    w_baudNext   = r_baud;
    w_bitIdxNext = r_bitIdx;
    w_lineNext   = r_line;
    w_pop        = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_baudNext = '0;
        w_lineNext = 1'b1;
        if (w_notEmpty) begin
          w_pop       = 1'b1;
          w_stateNext = START;
          w_lineNext  = 1'b0;
        end
      end
      START: begin
        w_lineNext = 1'b0;
        w_baudNext = r_baud + CNT_W'(1);
        if (w_baudDone) begin
          w_baudNext   = '0;
          w_bitIdxNext = 3'd0;
          w_stateNext  = DATA;
          w_lineNext   = r_shift[0];
        end
      end
      DATA: begin
        w_lineNext = r_shift[r_bitIdx];
        w_baudNext = r_baud + CNT_W'(1);
        if (w_baudDone) begin
          w_baudNext = '0;
          if (r_bitIdx == 3'd7) begin
            w_stateNext = STOP;
            w_lineNext  = 1'b1;
          end else begin
            w_bitIdxNext = w_bitIdxInc;
            w_lineNext   = r_shift[w_bitIdxInc];
          end
        end
      end
      STOP: begin
        w_lineNext = 1'b1;
        w_baudNext = r_baud + CNT_W'(1);
        if (w_baudDone) begin
          w_baudNext = '0;
          if (w_notEmpty) begin
            w_pop       = 1'b1;
            w_stateNext = START;
            w_lineNext  = 1'b0;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_lineNext  = 1'b1;
        w_baudNext  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_baud   <= '0;
      r_bitIdx <= 3'd0;
      r_shift  <= 8'd0;
      r_line   <= 1'b1;
    end else begin
      r_state  <= w_stateNext;
      r_baud   <= w_baudNext;
      r_bitIdx <= w_bitIdxNext;
      r_line   <= w_lineNext;
      if (w_pop) begin
        r_shift <= r_mem[r_rdPtr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PTR_W + 1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= tx_data;
    end
  end

  assign tx_full      = (r_count == DEPTH_CNT);
  assign tx_idle      = (r_state == IDLE) && !w_notEmpty;
  assign tx_overflow  = r_overflow;
  assign uart_tx_line = r_line;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A line receiver decodes frames and checks them against a byte scoreboard.
module tb_uart_transmitter;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_full;
  logic       tx_idle;
  logic       tx_overflow;
  logic       uart_tx_line;

  int         compareCount = 0;
  int         failCount    = 0;
  int         cycleCount   = 0;
  logic [7:0] sbQueue [$];
  int         frameStarts [$];

  logic [7:0] rxByte;
  logic [7:0] rxExpected;
  logic       rxStop;
  bit         rxAborted;
  int         baseCycle;
  int         idleCycle;
  bit         sawLow;

  uart_transmitter #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_full      (tx_full),
    .tx_idle      (tx_idle),
    .tx_overflow  (tx_overflow),
    .uart_tx_line (uart_tx_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one strobe sampled at the next rising edge; returns #1 after that edge.
  task automatic applyStimulus(input logic [7:0] d, input bit expectTx);
    tx_data       = d;
    tx_data_valid = 1'b1;
    if (expectTx) sbQueue.push_back(d);
    @(posedge clk);
    #1;
    tx_data_valid = 1'b0;
    tx_data       = 8'($urandom);
  endtask

  task automatic doReset();
    #2;
    rst = 1'b0;
    sbQueue.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int maxCycles, output int cyc);
    cyc = -1;
    for (int i = 0; i < maxCycles; i++) begin
      @(posedge clk);
      #1;
      if (tx_idle === 1'b1) begin
        cyc = cycleCount;
        return;
      end
    end
    checkOutput("idleTimeout", {31'd0, tx_idle}, 32'd1);
  endtask

  // Checks the 40 line cycles that follow a strobe into an idle transmitter.
  task automatic checkFrameWave(input logic [7:0] d, input string name);
    logic expLine;
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(posedge clk);
      #1;
      if (k <= CPB) expLine = 1'b0;
      else if (k <= 9 * CPB) expLine = d[(k - CPB - 1) / CPB];
      else expLine = 1'b1;
      checkOutput($sformatf("%s_line_c%0d", name, k), {31'd0, uart_tx_line}, {31'd0, expLine});
      checkOutput($sformatf("%s_idle_c%0d", name, k), {31'd0, tx_idle}, 32'd0);
    end
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s_idleAfter", name), {31'd0, tx_idle}, 32'd1);
    checkOutput($sformatf("%s_lineAfter", name), {31'd0, uart_tx_line}, 32'd1);
  endtask

  // Receiver: samples mid-bit on falling edges and checks against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && uart_tx_line === 1'b0) begin
        frameStarts.push_back(cycleCount);
        rxAborted = 1'b0;
        rxByte    = 8'd0;
        rxStop    = 1'b0;
        for (int n = 1; n <= 9 * CPB + 2; n++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            rxAborted = 1'b1;
            break;
          end
          if (n >= CPB + 2 && n <= 8 * CPB + 2 && ((n - CPB - 2) % CPB) == 0)
            rxByte[(n - CPB - 2) / CPB] = uart_tx_line;
          if (n == 9 * CPB + 2) rxStop = uart_tx_line;
        end
        if (!rxAborted) begin
          checkOutput("rxStopBit", {31'd0, rxStop}, 32'd1);
          if (sbQueue.size() == 0) begin
            checkOutput("rxUnexpectedByte", {24'd0, rxByte}, 32'hFFFF_FFFF);
          end else begin
            rxExpected = sbQueue.pop_front();
            checkOutput("rxByte", {24'd0, rxByte}, {24'd0, rxExpected});
          end
        end
      end
    end
  end

  initial begin
    rst           = 1'b0;
    tx_data       = 8'h00;
    tx_data_valid = 1'b0;
    #17;
    checkOutput("rstLine", {31'd0, uart_tx_line}, 32'd1);
    checkOutput("rstIdle", {31'd0, tx_idle}, 32'd1);
    checkOutput("rstFull", {31'd0, tx_full}, 32'd0);
    checkOutput("rstOverflow", {31'd0, tx_overflow}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5, 1'b1);
    checkOutput("t1_idleAtStrobe", {31'd0, tx_idle}, 32'd0);
    checkFrameWave(8'hA5, "t1");

    $display("[TB] back-to-back 0x55, 0x0F");
    frameStarts.delete();
    applyStimulus(8'h55, 1'b1);
    baseCycle = cycleCount;
    applyStimulus(8'h0F, 1'b1);
    waitIdle(200, idleCycle);
    checkOutput("t2_idleCycle", idleCycle, baseCycle + 81);
    checkOutput("t2_frameCount", frameStarts.size(), 2);
    if (frameStarts.size() >= 2) begin
      checkOutput("t2_firstStart", frameStarts[0], baseCycle + 1);
      checkOutput("t2_startGap", frameStarts[1] - frameStarts[0], 40);
    end
    checkOutput("t2_sbEmpty", sbQueue.size(), 0);

    $display("[TB] overflow 0x01..0x06");
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b1);
    checkOutput("t3_fullAfter05", {31'd0, tx_full}, 32'd1);
    checkOutput("t3_noOverflowYet", {31'd0, tx_overflow}, 32'd0);
    applyStimulus(8'h06, 1'b0);
    checkOutput("t3_overflowSet", {31'd0, tx_overflow}, 32'd1);
    checkOutput("t3_stillFull", {31'd0, tx_full}, 32'd1);
    repeat (35) @(posedge clk);
    #1;
    checkOutput("t3_fullBefore02Pop", {31'd0, tx_full}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("t3_fullClearsOn02Pop", {31'd0, tx_full}, 32'd0);
    waitIdle(400, idleCycle);
    checkOutput("t3_overflowSticky", {31'd0, tx_overflow}, 32'd1);
    checkOutput("t3_sbEmpty", sbQueue.size(), 0);

    $display("[TB] full with simultaneous pop");
    doReset();
    checkOutput("t4_overflowCleared", {31'd0, tx_overflow}, 32'd0);
    for (int i = 0; i < 5; i++) applyStimulus(8'h11 + 8'(i), 1'b1);
    checkOutput("t4_full", {31'd0, tx_full}, 32'd1);
    repeat (36) @(posedge clk);
    #1;
    checkOutput("t4_fullBeforePop", {31'd0, tx_full}, 32'd1);
    applyStimulus(8'h77, 1'b1);
    checkOutput("t4_noOverflow", {31'd0, tx_overflow}, 32'd0);
    checkOutput("t4_fullAfterSwap", {31'd0, tx_full}, 32'd1);
    waitIdle(400, idleCycle);
    checkOutput("t4_overflowStays0", {31'd0, tx_overflow}, 32'd0);
    checkOutput("t4_sbEmpty", sbQueue.size(), 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    applyStimulus(8'hBB, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    checkOutput("t5_dataBit3", {31'd0, uart_tx_line}, 32'd0);
    #2;
    rst = 1'b0;
    sbQueue.delete();
    #1;
    checkOutput("t5_asyncLine", {31'd0, uart_tx_line}, 32'd1);
    checkOutput("t5_asyncIdle", {31'd0, tx_idle}, 32'd1);
    checkOutput("t5_asyncFull", {31'd0, tx_full}, 32'd0);
    checkOutput("t5_asyncOverflow", {31'd0, tx_overflow}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    sawLow = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx_line !== 1'b1 || tx_idle !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("t5_noResidual", {31'd0, sawLow}, 32'd0);
    applyStimulus(8'h3C, 1'b1);
    checkFrameWave(8'h3C, "t5");
    checkOutput("t5_sbEmpty", sbQueue.size(), 0);

    $display("[TB] data extremes 0x00, 0xFF");
    applyStimulus(8'h00, 1'b1);
    checkFrameWave(8'h00, "t6zero");
    applyStimulus(8'hFF, 1'b1);
    checkFrameWave(8'hFF, "t6ones");
    repeat (4) @(posedge clk);
    checkOutput("t6_sbEmpty", sbQueue.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial transmitter sitting on the far end of the memory stage's UART output (tx_data / tx_data_valid).
- A store to the UART address in memory_access produces a one-cycle byte strobe. This block buffers the byte in a small FIFO and shifts it out as an 8N1 frame on a single line.
- It decouples the single-cycle core from the baud rate, so store instructions never stall.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal values >= 2.
- FIFO_DEPTH, 4, byte entries in the transmit FIFO; power of two, >= 2.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- tx_data  input  8  byte to transmit; sampled only when tx_data_valid = 1.
- tx_data_valid  input  1  one-cycle write strobe from the memory stage.
- tx_full  output  1  FIFO holds FIFO_DEPTH entries.
- tx_idle  output  1  FSM in IDLE and FIFO empty.
- tx_overflow  output  1  sticky flag: a write was dropped.
- uart_tx_line  output  1  serial line, registered; idle level 1.

Behaviour:
- Reset (rst = 0, asynchronous) forces:
  - uart_tx_line = 1, tx_idle = 1, tx_full = 0, tx_overflow = 0;
  - FIFO count = 0, read/write pointers = 0;
  - FSM = IDLE, bit and baud counters = 0.
- Asserting reset mid-frame aborts the frame immediately: the line goes high asynchronously and all queued bytes are discarded.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers that wrap naturally.
  - The count register has one extra bit.
  - A write is accepted when tx_data_valid = 1 and either count < FIFO_DEPTH or a pop occurs in the same cycle.
  - Otherwise the write is dropped, tx_overflow is set to 1, and the flag stays set until reset.
  - Simultaneous push and pop leaves count unchanged.
- FSM states are IDLE, START, DATA, STOP.
- IDLE:
  - If count > 0: pop the head into the shift register, go to START, zero the baud counter.
  - The line goes low on the same edge as the pop.
- START:
  - Line = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA:
  - Line = shift register bit[index], LSB first, for CLKS_PER_BIT cycles per bit.
  - After index 7 completes, go to STOP.
- STOP:
  - Line = 1 for CLKS_PER_BIT cycles.
  - At the end, if count > 0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter:
  - Counts 0 .. CLKS_PER_BIT-1 and advances the bit or state on the terminal count.
  - Width is clog2(CLKS_PER_BIT).
- Latency: a strobe on edge N into an empty FIFO with the FSM in IDLE pops on edge N+1, so the start bit begins at edge N+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles; back-to-back frames are exactly contiguous.
- tx_full and tx_idle are derived from registered state; no combinational path exists from tx_data_valid to any output.
- tx_data is ignored whenever tx_data_valid = 0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Single byte:
   - Stimulus: write 0xA5 at edge N.
   - Required: line = 0 for edges N+1..N+4; then data bits 1,0,1,0,0,1,0,1, four cycles each; then stop = 1 for four cycles.
   - Required: tx_idle = 0 for 40 cycles, then 1.
2. Back-to-back:
   - Stimulus: write 0x55 and 0x0F on consecutive cycles.
   - Required: two frames with no gap, 80 cycles total; the second start bit begins exactly 40 cycles after the first.
   - Required: the receiver model decodes 0x55 then 0x0F.
3. Overflow:
   - Stimulus: write 0x01..0x06 on six consecutive cycles starting at N.
   - Required: 0x01 pops at N+1; 0x02..0x05 fill the FIFO, so tx_full = 1 after N+4.
   - Required: 0x06 is dropped and tx_overflow = 1 and stays 1.
   - Required: exactly 0x01..0x05 are transmitted; tx_full clears when 0x02 pops.
4. Full with simultaneous pop:
   - Stimulus: fill the FIFO, then strobe 0x77 on the exact cycle STOP ends and a pop occurs.
   - Required: 0x77 is accepted, tx_overflow stays 0, and 0x77 is transmitted last.
5. Reset mid-frame:
   - Stimulus: pull rst low during data bit 3 of 0xC3 with two bytes queued.
   - Required: line = 1 immediately (asynchronous), tx_idle = 1, tx_full = 0, tx_overflow = 0.
   - Required: after release, no residual bits are sent; a new write of 0x3C transmits correctly.
6. Data extremes:
   - Stimulus: transmit 0x00 and 0xFF.
   - Required: 0x00 gives line 0 for 36 cycles (start + data), then stop = 1.
   - Required: 0xFF gives 0 for 4 cycles, then 1 for 36 cycles.
